// File: rtl/clkgen_pkg.sv
// ----------------------------------------------------------------------------
// clkgen_pkg
// Shared types and default constants for the post-MMCM tick sequencer.
//  - clkgen_state_e : lock-qualification FSM states
//  - DEF_*          : default parameter values used by the sequencer,
//                     its channel sub-module and its bus interface
//  - cnt_width()    : counter width helper that never returns 0
// ----------------------------------------------------------------------------
package clkgen_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RUN       = 2'd2
    } clkgen_state_e;

    localparam int DEF_NUM_CH      = 4;
    localparam int DEF_DIV_W       = 16;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_LOCK_HOLD   = 16;
    localparam int DEF_LOSS_W      = 8;

    // Bits needed to count 0..n-1; a 1-bit counter is kept for n <= 1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clkgen_tick_sequencer_if.sv
// ----------------------------------------------------------------------------
// clkgen_tick_sequencer_if
// Channel bus of the tick sequencer.
//  chan_en_i : per-channel enable            (master -> slave)
//  div_i     : per-channel divide values,     (master -> slave)
//              channel c at [c*DIV_W +: DIV_W]
//  tick_o    : one-cycle tick per period      (slave -> master)
//  phase_o   : divided square-wave level      (slave -> master)
// Modports: master = user logic, slave = clkgen_tick_sequencer.
// ----------------------------------------------------------------------------
interface clkgen_tick_sequencer_if
    import clkgen_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int DIV_W  = DEF_DIV_W
);
    logic [NUM_CH-1:0]       chan_en_i;
    logic [NUM_CH*DIV_W-1:0] div_i;
    logic [NUM_CH-1:0]       tick_o;
    logic [NUM_CH-1:0]       phase_o;

    modport master (
        output chan_en_i,
        output div_i,
        input  tick_o,
        input  phase_o
    );

    modport slave (
        input  chan_en_i,
        input  div_i,
        output tick_o,
        output phase_o
    );
endinterface

// File: rtl/clkgen_tick_chan.sv
// ----------------------------------------------------------------------------
// clkgen_tick_chan
// One programmable clock-enable channel.
//  clk_i, rst_i : clock, synchronous active-high reset
//  run          : sequencer is in RUN
//  en           : channel enable
//  div          : divide value D (0 and 1 both mean D=1)
//  tick         : high in the last cycle of every D-cycle period
//  phase        : high for the first ceil(D/2) cycles of every period
// While idle (not run or not enabled) the counter sits at 0 and the shadow
// follows div every cycle; once active, div is only taken at a period wrap
// so a running period is never shortened or stretched.
// ----------------------------------------------------------------------------
module clkgen_tick_chan
    import clkgen_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             run,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick,
    output logic             phase
);

    logic [DIV_W-1:0] count_reg;
    logic [DIV_W-1:0] count_next;
    logic [DIV_W-1:0] shadow_reg;
    logic [DIV_W-1:0] shadow_next;
    logic [DIV_W-1:0] last_count;
    logic [DIV_W:0]   period_len;
    logic [DIV_W:0]   high_len;
    logic             active;
    logic             wrap;

    always_comb begin
        active     = run & en;
        // Effective period D with 0/1 collapsed to 1; one extra bit so that
        // ceil(D/2) = (D+1)>>1 cannot overflow for an all-ones divide.
        period_len = (shadow_reg <= DIV_W'(1)) ? (DIV_W+1)'(1) : {1'b0, shadow_reg};
        high_len   = (period_len + (DIV_W+1)'(1)) >> 1;
        last_count = period_len[DIV_W-1:0] - DIV_W'(1);
        wrap       = (count_reg == last_count);

        count_next  = count_reg;
        shadow_next = shadow_reg;
        if (!active) begin
            count_next  = '0;
            shadow_next = div;
        end else if (wrap) begin
            count_next  = '0;
            shadow_next = div;
        end else begin
            count_next  = count_reg + DIV_W'(1);
        end

        tick  = active & wrap;
        phase = active & ({1'b0, count_reg} < high_len);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_reg  <= '0;
            shadow_reg <= '0;
        end else begin
            count_reg  <= count_next;
            shadow_reg <= shadow_next;
        end
    end

endmodule

// File: rtl/clkgen_tick_sequencer.sv
// ----------------------------------------------------------------------------
// clkgen_tick_sequencer
// Post-MMCM sequencer: synchronises MMCM LOCKED, holds the system reset until
// lock has been stable for LOCK_HOLD cycles, then runs NUM_CH phase-aligned
// programmable tick channels.
//  clk_i           : system clock (MMCM output via BUFG)
//  rst_i           : synchronous active-high reset
//  locked_i        : MMCM LOCKED, asynchronous to clk_i
//  chan_bus        : channel enables/divides in, ticks/phases out (slave)
//  rst_sys_o       : system reset, high whenever not in RUN
//  ready_o         : high while in RUN
//  lock_clr_i      : clears the lock-monitor status
//  lock_lost_o     : sticky lock-lost flag
//  lock_loss_cnt_o : saturating count of lock losses
// Build option: define CLKGEN_LOCK_MON_EN to enable the lock monitor; when it
// is undefined the monitor outputs are tied to 0 and lock_clr_i is ignored.
// ----------------------------------------------------------------------------
module clkgen_tick_sequencer
    import clkgen_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int DIV_W       = DEF_DIV_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int LOCK_HOLD   = DEF_LOCK_HOLD,
    parameter int LOSS_W      = DEF_LOSS_W
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      locked_i,
    clkgen_tick_sequencer_if.slave    chan_bus,
    output logic                      rst_sys_o,
    output logic                      ready_o,
    input  logic                      lock_clr_i,
    output logic                      lock_lost_o,
    output logic [LOSS_W-1:0]         lock_loss_cnt_o
);

    localparam int                HOLD_W    = cnt_width(LOCK_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LOCK_HOLD - 1);

    // ------------------------------------------------------------------
    // LOCKED synchroniser
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   lock_s;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], locked_i};
        end
    end

    assign lock_s = sync_reg[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Lock-qualification FSM
    // ------------------------------------------------------------------
    clkgen_state_e     state_reg;
    clkgen_state_e     state_next;
    logic [HOLD_W-1:0] hold_cnt_reg;
    logic [HOLD_W-1:0] hold_cnt_next;
    logic              loss_event;
    logic              run;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg    <= WAIT_LOCK;
            hold_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            hold_cnt_reg <= hold_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        hold_cnt_next = hold_cnt_reg;
        loss_event    = 1'b0;
        case (state_reg)
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_next    = HOLD;
                    hold_cnt_next = '0;
                end
            end
            HOLD: begin
                if (!lock_s) begin
                    state_next = WAIT_LOCK;
                end else if (hold_cnt_reg == HOLD_LAST) begin
                    state_next = RUN;
                end else begin
                    hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_next = WAIT_LOCK;
                    loss_event = 1'b1;
                end
            end
            default: begin
                state_next = WAIT_LOCK;
            end
        endcase
    end

    assign run       = (state_reg == RUN);
    assign ready_o   = run;
    assign rst_sys_o = ~run;

    // ------------------------------------------------------------------
    // Tick channels
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0] tick_vec;
    logic [NUM_CH-1:0] phase_vec;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
            clkgen_tick_chan #(
                .DIV_W (DIV_W)
            ) u_chan (
                .clk_i (clk_i),
                .rst_i (rst_i),
                .run   (run),
                .en    (chan_bus.chan_en_i[gi]),
                .div   (chan_bus.div_i[gi*DIV_W +: DIV_W]),
                .tick  (tick_vec[gi]),
                .phase (phase_vec[gi])
            );
        end
    endgenerate

    assign chan_bus.tick_o  = tick_vec;
    assign chan_bus.phase_o = phase_vec;

    // ------------------------------------------------------------------
    // Lock monitor
    // ------------------------------------------------------------------
`ifdef CLKGEN_LOCK_MON_EN
    logic              lock_lost_reg;
    logic [LOSS_W-1:0] loss_cnt_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_lost_reg <= 1'b0;
            loss_cnt_reg  <= '0;
        end else if (lock_clr_i) begin
            // A loss coinciding with the clear is counted as the first new one.
            lock_lost_reg <= loss_event;
            loss_cnt_reg  <= loss_event ? LOSS_W'(1) : '0;
        end else if (loss_event) begin
            lock_lost_reg <= 1'b1;
            if (loss_cnt_reg != {LOSS_W{1'b1}}) begin
                loss_cnt_reg <= loss_cnt_reg + LOSS_W'(1);
            end
        end
    end

    assign lock_lost_o     = lock_lost_reg;
    assign lock_loss_cnt_o = loss_cnt_reg;
`else
    logic lock_mon_unused;

    assign lock_mon_unused = lock_clr_i ^ loss_event;
    assign lock_lost_o     = 1'b0;
    assign lock_loss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_clkgen_tick_sequencer.sv
// ----------------------------------------------------------------------------
// tb_clkgen_tick_sequencer
// Self-checking bench for clkgen_tick_sequencer. The reference model tracks
// lock as a run-length of consecutive synchronised-lock samples and each
// channel as an absolute period start cycle plus period length.
// ----------------------------------------------------------------------------
module tb_clkgen_tick_sequencer;

    localparam int NUM_CH      = 4;
    localparam int DIV_W       = 16;
    localparam int SYNC_STAGES = 2;
    localparam int LOCK_HOLD   = 16;
    localparam int LOSS_W      = 8;
    localparam int CNT_MAX     = (1 << LOSS_W) - 1;
`ifdef CLKGEN_LOCK_MON_EN
    localparam bit MON_ON = 1'b1;
`else
    localparam bit MON_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              locked;
    logic              lock_clr;
    logic              rst_sys;
    logic              ready;
    logic              lock_lost;
    logic [LOSS_W-1:0] loss_cnt;

    int checks = 0;
    int errors = 0;

    clkgen_tick_sequencer_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) bus ();

    clkgen_tick_sequencer #(
        .NUM_CH      (NUM_CH),
        .DIV_W       (DIV_W),
        .SYNC_STAGES (SYNC_STAGES),
        .LOCK_HOLD   (LOCK_HOLD),
        .LOSS_W      (LOSS_W)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .locked_i        (locked),
        .chan_bus        (bus.slave),
        .rst_sys_o       (rst_sys),
        .ready_o         (ready),
        .lock_clr_i      (lock_clr),
        .lock_lost_o     (lock_lost),
        .lock_loss_cnt_o (loss_cnt)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    int cyc = 0;               // index of the current clock cycle
    int start_c [NUM_CH];      // cycle in which the channel's period began
    int len_c   [NUM_CH];      // length of that period
    bit hist    [SYNC_STAGES]; // locked_i delay line
    int streak  = 0;           // consecutive synced-lock samples
    bit m_ready = 1'b0;
    bit m_lost  = 1'b0;
    int m_cnt   = 0;

    function automatic int eff(input int d);
        return (d <= 1) ? 1 : d;
    endfunction

    function automatic logic [NUM_CH-1:0] exp_tick_f();
        logic [NUM_CH-1:0] v;
        v = '0;
        for (int c = 0; c < NUM_CH; c++)
            if (m_ready && bus.chan_en_i[c] && (cyc - start_c[c] == len_c[c] - 1)) v[c] = 1'b1;
        return v;
    endfunction

    function automatic logic [NUM_CH-1:0] exp_phase_f();
        logic [NUM_CH-1:0] v;
        v = '0;
        for (int c = 0; c < NUM_CH; c++)
            if (m_ready && bus.chan_en_i[c] && (cyc - start_c[c] < (len_c[c] + 1) / 2)) v[c] = 1'b1;
        return v;
    endfunction

    always @(posedge clk) begin : model
        int n_start [NUM_CH];
        int n_len   [NUM_CH];
        bit n_hist  [SYNC_STAGES];
        int n_streak;
        bit n_ready;
        bit n_lost;
        int n_cnt;
        bit loss;
        int d;
        for (int c = 0; c < NUM_CH; c++) begin
            d = int'(bus.div_i[c*DIV_W +: DIV_W]);
            n_start[c] = start_c[c];
            n_len[c]   = len_c[c];
            if (rst) begin
                n_start[c] = cyc + 1;
                n_len[c]   = 1;
            end else if (!(m_ready && bus.chan_en_i[c]) || (cyc - start_c[c] == len_c[c] - 1)) begin
                n_start[c] = cyc + 1;
                n_len[c]   = eff(d);
            end
        end
        n_lost = m_lost;
        n_cnt  = m_cnt;
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) n_hist[i] = 1'b0;
            n_streak = 0;
            n_ready  = 1'b0;
            n_lost   = 1'b0;
            n_cnt    = 0;
        end else begin
            for (int i = SYNC_STAGES - 1; i > 0; i--) n_hist[i] = hist[i-1];
            n_hist[0] = locked;
            n_streak  = hist[SYNC_STAGES-1] ? ((streak > LOCK_HOLD) ? streak : streak + 1) : 0;
            n_ready   = (n_streak >= LOCK_HOLD + 1);
            loss      = m_ready && !n_ready;
            if (MON_ON) begin
                if (lock_clr) begin
                    n_lost = loss;
                    n_cnt  = loss ? 1 : 0;
                end else if (loss) begin
                    n_lost = 1'b1;
                    n_cnt  = (m_cnt >= CNT_MAX) ? CNT_MAX : m_cnt + 1;
                end
            end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            start_c[c] <= n_start[c];
            len_c[c]   <= n_len[c];
        end
        for (int i = 0; i < SYNC_STAGES; i++) hist[i] <= n_hist[i];
        streak  <= n_streak;
        m_ready <= n_ready;
        m_lost  <= n_lost;
        m_cnt   <= n_cnt;
        cyc     <= cyc + 1;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_div(input int c, input int v);
        bus.div_i[c*DIV_W +: DIV_W] = DIV_W'(v);
    endtask

    task automatic set_divs_5421();
        set_div(0, 1); set_div(1, 2); set_div(2, 4); set_div(3, 5);
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1; locked = 1'b1; bus.chan_en_i = '1; set_divs_5421();
        repeat (3) next_cycle();
        checks += 6;
        if (rst_sys !== 1'b1) begin errors++; $display("FAIL reset_rst_sys: got %b want 1", rst_sys); end
        if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready); end
        if (bus.tick_o !== '0) begin errors++; $display("FAIL reset_tick: got %b want 0000", bus.tick_o); end
        if (bus.phase_o !== '0) begin errors++; $display("FAIL reset_phase: got %b want 0000", bus.phase_o); end
        if (lock_lost !== 1'b0) begin errors++; $display("FAIL reset_lost: got %b want 0", lock_lost); end
        if (loss_cnt !== '0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", loss_cnt); end
        $display("test_reset done");
    endtask

    // locked_i high from edge 0: reset held through edge 17, released after 18.
    task automatic test_release();
        logic exp_rst;
        rst = 1'b0; locked = 1'b1;
        for (int k = 0; k <= 18; k++) begin
            next_cycle();
            exp_rst = (k <= 17);
            checks += 3;
            if (rst_sys !== exp_rst) begin errors++; $display("FAIL release_rst_sys edge %0d: got %b want %b", k, rst_sys, exp_rst); end
            if (ready !== !exp_rst) begin errors++; $display("FAIL release_ready edge %0d: got %b want %b", k, ready, !exp_rst); end
            if (rst_sys !== !m_ready) begin errors++; $display("FAIL release_model edge %0d: got %b want %b", k, rst_sys, !m_ready); end
        end
        $display("test_release done");
    endtask

    // div={1,2,4,5}, all enabled before RUN: phase-aligned from RUN cycle 0.
    task automatic test_aligned_ticks();
        logic [NUM_CH-1:0] et, ep;
        for (int r = 0; r < 20; r++) begin
            et = {(r % 5 == 4), (r % 4 == 3), (r % 2 == 1), 1'b1};
            ep = {(r % 5 < 3),  (r % 4 < 2),  (r % 2 == 0), 1'b1};
            checks += 3;
            if (bus.tick_o !== et) begin errors++; $display("FAIL aligned_tick run %0d: got %b want %b", r, bus.tick_o, et); end
            if (bus.phase_o !== ep) begin errors++; $display("FAIL aligned_phase run %0d: got %b want %b", r, bus.phase_o, ep); end
            if (bus.tick_o !== exp_tick_f()) begin errors++; $display("FAIL aligned_model run %0d: got %b want %b", r, bus.tick_o, exp_tick_f()); end
            next_cycle();
        end
        $display("test_aligned_ticks done");
    endtask

    // Lock drops for 3 samples mid-HOLD: full hold restarts, release at edge 33.
    task automatic test_hold_restart();
        int first_ready;
        rst = 1'b1; next_cycle();
        rst = 1'b0; locked = 1'b1;
        bus.chan_en_i = 4'b0101;
        set_div(0, 0); set_div(1, 3); set_div(2, 4); set_div(3, 7);
        first_ready = -1;
        for (int k = 0; k <= 33; k++) begin
            if (k == 12) locked = 1'b0;
            if (k == 15) locked = 1'b1;
            next_cycle();
            checks++;
            if (rst_sys !== !m_ready) begin errors++; $display("FAIL hold_model edge %0d: got %b want %b", k, rst_sys, !m_ready); end
            if (ready === 1'b1 && first_ready < 0) first_ready = k;
        end
        checks++;
        if (first_ready != 33) begin errors++; $display("FAIL hold_release_edge: got %0d want 33", first_ready); end
        $display("test_hold_restart done");
    endtask

    // ch2 div 4->6 at count 1: ticks at 3, then 9 and 15. ch0 div=0 ticks always.
    task automatic test_div_change();
        logic e2;
        for (int r = 0; r <= 16; r++) begin
            if (r == 1) set_div(2, 6);
            e2 = (r == 3) || (r == 9) || (r == 15);
            checks += 4;
            if (bus.tick_o[2] !== e2) begin errors++; $display("FAIL divchg_tick2 run %0d: got %b want %b", r, bus.tick_o[2], e2); end
            if (bus.tick_o[0] !== 1'b1) begin errors++; $display("FAIL div0_tick run %0d: got %b want 1", r, bus.tick_o[0]); end
            if (bus.tick_o !== exp_tick_f()) begin errors++; $display("FAIL divchg_model_tick run %0d: got %b want %b", r, bus.tick_o, exp_tick_f()); end
            if (bus.phase_o !== exp_phase_f()) begin errors++; $display("FAIL divchg_model_phase run %0d: got %b want %b", r, bus.phase_o, exp_phase_f()); end
            next_cycle();
        end
        $display("test_div_change done");
    endtask

    task automatic test_lock_loss();
        logic prev_ready;
        bus.chan_en_i = '1; set_divs_5421();
        next_cycle();
        locked = 1'b0;
        prev_ready = ready;
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            checks += 3;
            if (rst_sys !== !m_ready) begin errors++; $display("FAIL loss_rst_sys cyc %0d: got %b want %b", i, rst_sys, !m_ready); end
            if (bus.tick_o !== exp_tick_f()) begin errors++; $display("FAIL loss_tick cyc %0d: got %b want %b", i, bus.tick_o, exp_tick_f()); end
            if (lock_lost !== m_lost) begin errors++; $display("FAIL loss_flag_model cyc %0d: got %b want %b", i, lock_lost, m_lost); end
            if (prev_ready === 1'b1 && ready === 1'b0) begin
                checks += 2;
                if (bus.tick_o !== '0) begin errors++; $display("FAIL loss_tick_stop: got %b want 0000", bus.tick_o); end
                if (rst_sys !== 1'b1) begin errors++; $display("FAIL loss_rst_sys_rise: got %b want 1", rst_sys); end
            end
            prev_ready = ready;
        end
        checks += 2;
        if (lock_lost !== MON_ON) begin errors++; $display("FAIL loss_flag: got %b want %b", lock_lost, MON_ON); end
        if (loss_cnt !== LOSS_W'(MON_ON ? 1 : 0)) begin errors++; $display("FAIL loss_cnt: got %0d want %0d", loss_cnt, MON_ON ? 1 : 0); end
        // Second loss with the clear landing on the same edge.
        locked = 1'b1;
        repeat (20) next_cycle();
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL relock_ready: got %b want 1", ready); end
        locked = 1'b0;
        next_cycle();
        next_cycle();
        lock_clr = 1'b1;
        next_cycle();
        lock_clr = 1'b0;
        checks += 3;
        if (ready !== 1'b0) begin errors++; $display("FAIL clrloss_ready: got %b want 0", ready); end
        if (lock_lost !== MON_ON) begin errors++; $display("FAIL clrloss_flag: got %b want %b", lock_lost, MON_ON); end
        if (loss_cnt !== LOSS_W'(MON_ON ? 1 : 0)) begin errors++; $display("FAIL clrloss_cnt: got %0d want %0d", loss_cnt, MON_ON ? 1 : 0); end
        $display("test_lock_loss done");
    endtask

    task automatic test_saturation();
        for (int n = 0; n < 300; n++) begin
            locked = 1'b1;
            repeat (20) next_cycle();
            locked = 1'b0;
            repeat (4) next_cycle();
            if (n == 100) begin
                checks++;
                if (loss_cnt !== LOSS_W'(m_cnt)) begin errors++; $display("FAIL sat_mid_cnt: got %0d want %0d", loss_cnt, m_cnt); end
            end
        end
        checks += 2;
        if (loss_cnt !== LOSS_W'(MON_ON ? CNT_MAX : 0)) begin errors++; $display("FAIL sat_cnt: got %0d want %0d", loss_cnt, MON_ON ? CNT_MAX : 0); end
        if (lock_lost !== MON_ON) begin errors++; $display("FAIL sat_flag: got %b want %b", lock_lost, MON_ON); end
        lock_clr = 1'b1;
        next_cycle();
        lock_clr = 1'b0;
        checks += 2;
        if (loss_cnt !== '0) begin errors++; $display("FAIL clr_cnt: got %0d want 0", loss_cnt); end
        if (lock_lost !== 1'b0) begin errors++; $display("FAIL clr_flag: got %b want 0", lock_lost); end
        $display("test_saturation done");
    endtask

    // rst_i in RUN with ch1 on its tick cycle: everything back to reset values.
    task automatic test_reset_in_run();
        logic [NUM_CH-1:0] et;
        bus.chan_en_i = '1; set_divs_5421();
        locked = 1'b1;
        repeat (21) next_cycle();
        for (int i = 0; i < 4; i++) begin
            et = exp_tick_f();
            if (et[1]) break;
            next_cycle();
        end
        checks++;
        if (bus.tick_o[1] !== 1'b1) begin errors++; $display("FAIL rstrun_pre_tick1: got %b want 1", bus.tick_o[1]); end
        rst = 1'b1;
        next_cycle();
        checks += 6;
        if (rst_sys !== 1'b1) begin errors++; $display("FAIL rstrun_rst_sys: got %b want 1", rst_sys); end
        if (ready !== 1'b0) begin errors++; $display("FAIL rstrun_ready: got %b want 0", ready); end
        if (bus.tick_o !== '0) begin errors++; $display("FAIL rstrun_tick: got %b want 0000", bus.tick_o); end
        if (bus.phase_o !== '0) begin errors++; $display("FAIL rstrun_phase: got %b want 0000", bus.phase_o); end
        if (lock_lost !== 1'b0) begin errors++; $display("FAIL rstrun_lost: got %b want 0", lock_lost); end
        if (loss_cnt !== '0) begin errors++; $display("FAIL rstrun_cnt: got %0d want 0", loss_cnt); end
        rst = 1'b0;
        $display("test_reset_in_run done");
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) bus.chan_en_i = NUM_CH'($urandom);
            if ($urandom_range(0, 7) == 0) set_div(int'($urandom_range(0, NUM_CH - 1)), int'($urandom_range(0, 9)));
            locked   = ($urandom_range(0, 99) != 0);
            lock_clr = ($urandom_range(0, 49) == 0);
            rst      = ($urandom_range(0, 999) == 0);
            next_cycle();
            checks += 6;
            if (rst_sys !== !m_ready) begin errors++; $display("FAIL rand_rst_sys %0d: got %b want %b", i, rst_sys, !m_ready); end
            if (ready !== m_ready) begin errors++; $display("FAIL rand_ready %0d: got %b want %b", i, ready, m_ready); end
            if (bus.tick_o !== exp_tick_f()) begin errors++; $display("FAIL rand_tick %0d: got %b want %b", i, bus.tick_o, exp_tick_f()); end
            if (bus.phase_o !== exp_phase_f()) begin errors++; $display("FAIL rand_phase %0d: got %b want %b", i, bus.phase_o, exp_phase_f()); end
            if (lock_lost !== m_lost) begin errors++; $display("FAIL rand_lost %0d: got %b want %b", i, lock_lost, m_lost); end
            if (loss_cnt !== LOSS_W'(m_cnt)) begin errors++; $display("FAIL rand_cnt %0d: got %0d want %0d", i, loss_cnt, m_cnt); end
        end
        rst = 1'b0; lock_clr = 1'b0;
        $display("test_random done");
    endtask

    initial begin
        rst = 1'b1; locked = 1'b0; lock_clr = 1'b0;
        bus.chan_en_i = '0; bus.div_i = '0;
        test_reset();
        test_release();
        test_aligned_ticks();
        test_hold_restart();
        test_div_change();
        test_lock_loss();
        test_saturation();
        test_reset_in_run();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
